// File: rtl/dsky_keypad_scanner.sv
// DSKY 4x5 key matrix scanner, debouncer and AGC channel-15 keycode encoder.
// Optional macro KEYPAD_GHOST_REJECT_EN: ignore frames with two or more non-PRO closures.
module dsky_keypad_scanner #(
   parameter int unsigned SCAN_DIV        = 256,
   parameter int unsigned DEBOUNCE_FRAMES = 40
) (
   input  logic       SIM_CLK,
   input  logic       SIM_RST_n,
   output logic [3:0] ROW_n,
   input  logic [4:0] COL_n,
   output logic [4:0] MKEY,
   output logic       PROCEED,
   output logic       KEY_STB
);

   localparam int unsigned SlotW = $clog2(SCAN_DIV);
   localparam int unsigned CntW  = $clog2(DEBOUNCE_FRAMES + 1);
   localparam logic [SlotW-1:0] SlotLast = SlotW'(SCAN_DIV - 1);
   localparam logic [CntW-1:0]  CntMax   = CntW'(DEBOUNCE_FRAMES);
   localparam logic [CntW-1:0]  CntOne   = CntW'(1);

`ifdef KEYPAD_GHOST_REJECT_EN
   localparam bit GhostReject = 1'b1;
`else
   localparam bit GhostReject = 1'b0;
`endif

   typedef enum logic [1:0] {StIdle, StPressWait, StHeld, StReleaseWait} state_e;

   logic [4:0]       col_meta_q, col_sync_q, closed;
   logic [SlotW-1:0] slot_q;
   logic [1:0]       row_q;
   logic [14:0]      frame_q;
   logic [18:0]      frame_full;
   logic             slot_end, frame_done;
   logic             found, multi, no_info;
   logic [4:0]       first_idx, code;
   state_e           state_q, state_d;
   logic [4:0]       cand_q, cand_d, mkey_q, mkey_d;
   logic [CntW-1:0]  cnt_q, cnt_d, cnt_inc;
   logic             stb_q, stb_d, pro_q, pro_d;
   logic [CntW-1:0]  pro_cnt_q, pro_cnt_d, pro_cnt_inc;

   assign closed     = ~col_sync_q;
   assign slot_end   = (slot_q == SlotLast);
   assign frame_done = slot_end && (row_q == 2'd3);
   // Row 3 is still in the synchronizer when its frame completes; the unused column is dropped.
   assign frame_full = {closed[3:0], frame_q};
   assign ROW_n      = ~(4'b0001 << row_q);

   always_ff @(posedge SIM_CLK or negedge SIM_RST_n) begin
      if (!SIM_RST_n) begin
         col_meta_q <= 5'b11111;
         col_sync_q <= 5'b11111;
         slot_q     <= '0;
         row_q      <= '0;
         frame_q    <= '0;
      end else begin
         col_meta_q <= COL_n;
         col_sync_q <= col_meta_q;
         if (slot_end) begin
            slot_q <= '0;
            row_q  <= row_q + 2'd1;
            case (row_q)
               2'd0:    frame_q[4:0]   <= closed;
               2'd1:    frame_q[9:5]   <= closed;
               2'd2:    frame_q[14:10] <= closed;
               default: ;
            endcase
         end else begin
            slot_q <= slot_q + 1'b1;
         end
      end
   end

   // Row-major scan for the lowest non-PRO closure; any second closure marks the frame MULTI.
   always_comb begin
      found     = 1'b0;
      multi     = 1'b0;
      first_idx = '0;
      for (int p = 0; p < 19; p++) begin
         if (p != 15 && frame_full[p]) begin
            if (found) begin
               multi = 1'b1;
            end else begin
               found     = 1'b1;
               first_idx = 5'(p);
            end
         end
      end
      no_info = multi && GhostReject;
   end

   always_comb begin
      case (first_idx)
         5'd0:    code = 5'o21;
         5'd1:    code = 5'o32;
         5'd2:    code = 5'o07;
         5'd3:    code = 5'o10;
         5'd4:    code = 5'o11;
         5'd5:    code = 5'o37;
         5'd6:    code = 5'o33;
         5'd7:    code = 5'o04;
         5'd8:    code = 5'o05;
         5'd9:    code = 5'o06;
         5'd10:   code = 5'o36;
         5'd11:   code = 5'o20;
         5'd12:   code = 5'o01;
         5'd13:   code = 5'o02;
         5'd14:   code = 5'o03;
         5'd16:   code = 5'o31;
         5'd17:   code = 5'o34;
         5'd18:   code = 5'o22;
         default: code = 5'o00;
      endcase
   end

   assign cnt_inc     = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
   assign pro_cnt_inc = pro_cnt_q + 1'b1;

   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      mkey_d  = mkey_q;
      stb_d   = 1'b0;
      if (frame_done && !no_info) begin
         case (state_q)
            StIdle: begin
               if (found) begin
                  cand_d = code;
                  cnt_d  = CntOne;
                  if (CntMax == CntOne) begin
                     state_d = StHeld;
                     mkey_d  = code;
                     stb_d   = 1'b1;
                  end else begin
                     state_d = StPressWait;
                  end
               end
            end
            StPressWait: begin
               if (!found) begin
                  state_d = StIdle;
                  cnt_d   = '0;
               end else if (code == cand_q) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == CntMax) begin
                     state_d = StHeld;
                     mkey_d  = cand_q;
                     stb_d   = 1'b1;
                  end
               end else begin
                  cand_d = code;
                  cnt_d  = CntOne;
               end
            end
            StHeld: begin
               if (!found) begin
                  if (CntMax == CntOne) begin
                     state_d = StIdle;
                     mkey_d  = '0;
                     cnt_d   = '0;
                  end else begin
                     state_d = StReleaseWait;
                     cnt_d   = CntOne;
                  end
               end
            end
            default: begin
               if (!found) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == CntMax) begin
                     state_d = StIdle;
                     mkey_d  = '0;
                     cnt_d   = '0;
                  end
               end else begin
                  state_d = StHeld;
                  cnt_d   = '0;
               end
            end
         endcase
      end
   end

   // PROCEED debounces on the PRO bit alone, independent of the keycode FSM.
   always_comb begin
      pro_d     = pro_q;
      pro_cnt_d = pro_cnt_q;
      if (frame_done) begin
         if (frame_full[15] != pro_q) begin
            if (pro_cnt_inc == CntMax) begin
               pro_d     = ~pro_q;
               pro_cnt_d = '0;
            end else begin
               pro_cnt_d = pro_cnt_inc;
            end
         end else begin
            pro_cnt_d = '0;
         end
      end
   end

   always_ff @(posedge SIM_CLK or negedge SIM_RST_n) begin
      if (!SIM_RST_n) begin
         state_q   <= StIdle;
         cand_q    <= '0;
         cnt_q     <= '0;
         mkey_q    <= '0;
         stb_q     <= 1'b0;
         pro_q     <= 1'b0;
         pro_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         cand_q    <= cand_d;
         cnt_q     <= cnt_d;
         mkey_q    <= mkey_d;
         stb_q     <= stb_d;
         pro_q     <= pro_d;
         pro_cnt_q <= pro_cnt_d;
      end
   end

   assign MKEY    = mkey_q;
   assign KEY_STB = stb_q;
   assign PROCEED = pro_q;

endmodule

// File: tb/tb_dsky_keypad_scanner.sv
// Scoreboard bench for dsky_keypad_scanner: frame-level key model feeds expected MKEY/PROCEED
// changes into queues; a monitor pops them as the DUT outputs change.
module tb_dsky_keypad_scanner;

   localparam int SD = 8;
   localparam int DF = 3;
`ifdef KEYPAD_GHOST_REJECT_EN
   localparam bit Ghost = 1'b1;
`else
   localparam bit Ghost = 1'b0;
`endif

   logic       SIM_CLK = 1'b0;
   logic       SIM_RST_n = 1'b1;
   logic [3:0] ROW_n;
   logic [4:0] COL_n;
   logic [4:0] MKEY;
   logic       PROCEED, KEY_STB;
   logic [19:0] keys = '0;

   int checks = 0, failures = 0;
   int cyc = 0, frame_no = 0, last_mkey_cyc = 0, t_apply = 0;
   int exp_mkey[$];
   int exp_pro[$];

   // Model state: displayed code, run length, candidate, PROCEED level and its run.
   int m_disp = 0, m_run = 0, m_code = 0, m_pro = 0, m_pro_run = 0;
   int code_tbl[20] = '{8'o21, 8'o32, 8'o07, 8'o10, 8'o11, 8'o37, 8'o33, 8'o04, 8'o05, 8'o06,
                        8'o36, 8'o20, 8'o01, 8'o02, 8'o03, 0, 8'o31, 8'o34, 8'o22, 0};

   dsky_keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
      .SIM_CLK  (SIM_CLK),
      .SIM_RST_n(SIM_RST_n),
      .ROW_n    (ROW_n),
      .COL_n    (COL_n),
      .MKEY     (MKEY),
      .PROCEED  (PROCEED),
      .KEY_STB  (KEY_STB)
   );

   always #5 SIM_CLK = ~SIM_CLK;

   // Physical matrix: a closed key pulls its column low while its row is driven.
   always_comb begin
      COL_n = 5'b11111;
      for (int r = 0; r < 4; r++)
         if (ROW_n[r] == 1'b0) COL_n = COL_n & ~keys[5*r +: 5];
   end

   initial forever begin
      @(posedge SIM_CLK);
      cyc++;
   end

   initial begin
      logic [3:0] prev_row;
      prev_row = 4'b1110;
      forever begin
         @(negedge SIM_CLK);
         if (SIM_RST_n && prev_row == 4'b0111 && ROW_n == 4'b1110) frame_no++;
         prev_row = ROW_n;
      end
   end

   initial begin
      logic [4:0] pm;
      logic       pp;
      int         e;
      pm = '0;
      pp = 1'b0;
      forever begin
         @(negedge SIM_CLK);
         if (MKEY !== pm) begin
            checks++;
            if (exp_mkey.size() == 0) begin
               failures++;
               $display("FAIL mkey_unexpected got=%0o want=no_change", MKEY);
            end else begin
               e = exp_mkey.pop_front();
               if (MKEY !== 5'(e) || KEY_STB !== (e != 0)) begin
                  failures++;
                  $display("FAIL mkey_change got=%0o stb=%0b want=%0o stb=%0b", MKEY, KEY_STB,
                           e, (e != 0));
               end
            end
            last_mkey_cyc = cyc;
         end else if (KEY_STB !== 1'b0) begin
            checks++;
            failures++;
            $display("FAIL key_stb_spurious got=%0b want=0 mkey=%0o", KEY_STB, MKEY);
         end
         if (PROCEED !== pp) begin
            checks++;
            if (exp_pro.size() == 0) begin
               failures++;
               $display("FAIL proceed_unexpected got=%0b want=no_change", PROCEED);
            end else begin
               e = exp_pro.pop_front();
               if (PROCEED !== 1'(e)) begin
                  failures++;
                  $display("FAIL proceed_change got=%0b want=%0d", PROCEED, e);
               end
            end
         end
         pm = MKEY;
         pp = PROCEED;
      end
   end

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s got=%0o want=%0o", name, got, want);
      end
   endtask

   task automatic chk_range(input string name, input int got, input int lo, input int hi);
      checks++;
      if (got < lo || got > hi) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d..%0d", name, got, lo, hi);
      end
   endtask

   // One frame of the keypad as seen by the debouncer, applied from the classification rules.
   function automatic void model_frame(input logic [19:0] m);
      int cnt, low, code;
      bit none, no_info;
      cnt = 0;
      low = -1;
      for (int p = 0; p < 19; p++) begin
         if (p != 15 && m[p]) begin
            cnt++;
            if (low < 0) low = p;
         end
      end
      none = (cnt == 0);
      code = none ? 0 : code_tbl[low];
      no_info = Ghost && cnt >= 2;
      if (!no_info) begin
         if (m_disp == 0) begin
            if (none) m_run = 0;
            else if (m_run > 0 && code == m_code) m_run++;
            else begin
               m_code = code;
               m_run  = 1;
            end
            if (m_run >= DF) begin
               m_disp = m_code;
               m_run  = 0;
               exp_mkey.push_back(m_disp);
            end
         end else begin
            if (none) m_run++;
            else m_run = 0;
            if (m_run >= DF) begin
               m_disp = 0;
               m_run  = 0;
               exp_mkey.push_back(0);
            end
         end
      end
      if (int'(m[15]) != m_pro) m_pro_run++;
      else m_pro_run = 0;
      if (m_pro_run >= DF) begin
         m_pro     = 1 - m_pro;
         m_pro_run = 0;
         exp_pro.push_back(m_pro);
      end
   endfunction

   task automatic wait_frame_start();
      int f, n;
      f = frame_no;
      n = 0;
      while (frame_no == f && n < 200) begin
         @(negedge SIM_CLK);
         #1;
         n++;
      end
      if (frame_no == f) begin
         checks++;
         failures++;
         $display("FAIL frame_start_timeout got=%0d want=%0d", frame_no, f + 1);
      end
   endtask

   task automatic apply_seg(input logic [19:0] m, input int n);
      for (int i = 0; i < n; i++) begin
         wait_frame_start();
         if (i == 0) begin
            keys    = m;
            t_apply = cyc;
         end
         model_frame(m);
      end
   endtask

   task automatic reset_mid();
      if (m_disp != 0) exp_mkey.push_back(0);
      if (m_pro != 0) exp_pro.push_back(0);
      SIM_RST_n = 1'b0;
      keys      = '0;
      #1;
      chk("rst_mid_mkey", MKEY, 0);
      chk("rst_mid_row", ROW_n, 4'b1110);
      chk("rst_mid_proceed", PROCEED, 0);
      m_disp = 0; m_run = 0; m_code = 0; m_pro = 0; m_pro_run = 0;
      repeat (3) @(negedge SIM_CLK);
      SIM_RST_n = 1'b1;
   endtask

   initial begin
      logic [19:0] m;
      int          k, a, b;
      #1 SIM_RST_n = 1'b0;
      #2;
      chk("reset_mkey", MKEY, 0);
      chk("reset_row", ROW_n, 4'b1110);
      chk("reset_proceed", PROCEED, 0);
      chk("reset_stb", KEY_STB, 0);
      repeat (3) @(negedge SIM_CLK);
      SIM_RST_n = 1'b1;

      // Row walk, then idle frames.
      wait_frame_start();
      for (int i = 0; i < 4; i++) begin
         chk("row_walk", ROW_n, 4'(~(4'b0001 << i)));
         repeat (SD) @(negedge SIM_CLK);
         #1;
      end
      apply_seg(20'd0, 10);

      // "5" steady press and release with latency windows.
      apply_seg(20'd1 << 8, 5);
      chk("key5_mkey", MKEY, 5'o05);
      chk_range("key5_press_latency", last_mkey_cyc - t_apply, 96, 131);
      apply_seg(20'd0, 5);
      chk("key5_release_mkey", MKEY, 0);
      chk_range("key5_release_latency", last_mkey_cyc - t_apply, 96, 131);

      // Short press rejected.
      apply_seg(20'd1 << 8, 2);
      apply_seg(20'd0, 4);
      chk("short_press_mkey", MKEY, 0);

      // VERB with one-frame bounce open.
      apply_seg(20'd1 << 0, 4);
      apply_seg(20'd0, 1);
      apply_seg(20'd1 << 0, 4);
      chk("verb_bounce_mkey", MKEY, 5'o21);
      apply_seg(20'd0, 4);

      // PRO alone, then PRO + ENTR.
      apply_seg(20'd1 << 15, 4);
      chk("pro_proceed", PROCEED, 1);
      chk("pro_mkey", MKEY, 0);
      apply_seg((20'd1 << 15) | (20'd1 << 17), 4);
      chk("pro_entr_mkey", MKEY, 5'o34);
      chk("pro_entr_proceed", PROCEED, 1);
      apply_seg(20'd1 << 15, 4);
      apply_seg(20'd0, 4);
      chk("pro_release", PROCEED, 0);

      // "7" + "8" rollover, then reset while a key is held.
      apply_seg((20'd1 << 2) | (20'd1 << 3), 4);
      chk("rollover_mkey", MKEY, Ghost ? 0 : 5'o07);
      apply_seg(20'd1 << 4, 4);
      chk("held_before_reset", MKEY, Ghost ? 5'o11 : 5'o07);
      reset_mid();

      // Randomized segments.
      for (int s = 0; s < 40; s++) begin
         m = '0;
         k = $urandom_range(0, 3);
         a = $urandom_range(0, 19);
         b = $urandom_range(0, 19);
         case (k)
            1: m[a] = 1'b1;
            2: begin m[15] = 1'b1; m[a] = 1'b1; end
            3: begin m[a] = 1'b1; m[b] = 1'b1; end
            default: ;
         endcase
         apply_seg(m, $urandom_range(1, 5));
      end
      apply_seg(20'd0, 6);
      wait_frame_start();
      chk("exp_mkey_drained", exp_mkey.size(), 0);
      chk("exp_pro_drained", exp_pro.size(), 0);
      chk("final_mkey", MKEY, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
